// File: rtl/yubex_la_pkg.sv
// Shared definitions for the tiny logic analyzer capture path.
// Holds the sequencer state encoding and the trigger mode codes; the
// display mapping block decodes the same values, so keep them in one place.
// No ports (package).
package yubex_la_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } la_state_t;

  localparam logic [1:0] TRIG_RISE = 2'b00;
  localparam logic [1:0] TRIG_FALL = 2'b01;
  localparam logic [1:0] TRIG_HIGH = 2'b10;
  localparam logic [1:0] TRIG_LOW  = 2'b11;

  // Trigger condition between the previous strobed sample and the current one.
  function automatic logic trig_hit(input logic [1:0] mode, input logic prev,
                                    input logic s);
    case (mode)
      TRIG_RISE: return ~prev & s;
      TRIG_FALL: return prev & ~s;
      TRIG_HIGH: return s;
      default:   return ~s;
    endcase
  endfunction

endpackage

// File: rtl/yubex_la_strobe_gen.sv
// Sample-rate strobe generator.
// A counter runs 0..div while enabled and strobe is high on the wrap cycle,
// giving one strobe every div+1 clocks (div=0 -> every clock).
// Ports:
//   clk    in  1      system clock
//   rst    in  1      synchronous active-high reset
//   en     in  1      count enable (sequencer in ARMED/CAPTURE)
//   clr    in  1      restart the count at 0
//   div    in  DIV_W  wrap value (already latched by the sequencer)
//   strobe out 1      sample strobe
module yubex_la_strobe_gen #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt;

  assign strobe = en & (cnt == div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == div) cnt <= '0;
      else            cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/yubex_la_capture_ctrl.sv
// Trigger/capture sequencer for the logic analyzer's single-channel path.
// Arms on a rising edge of arm, waits for the selected trigger condition on
// strobed samples, records DEPTH samples (trigger sample at index 0) and then
// serves them one at a time through rd_data/rd_ptr.
// Ports:
//   clk       in  1      system clock
//   rst       in  1      synchronous active-high reset
//   data_in   in  1      synchronised sample input
//   arm       in  1      level; rising edge requests arming
//   abort     in  1      level; return to IDLE
//   trig_mode in  2      00 rise, 01 fall, 10 high, 11 low (live)
//   div       in  DIV_W  strobe every div+1 clocks, latched on arm
//   rd_next   in  1      advance read pointer (DONE only)
//   armed     out 1      state is ARMED
//   capturing out 1      state is CAPTURE
//   done      out 1      state is DONE, buffer valid
//   rd_data   out 1      sample at rd_ptr while done, else 0
//   rd_ptr    out PTR_W  read index
module yubex_la_capture_ctrl
  import yubex_la_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             arm,
  input  logic             abort,
  input  logic [1:0]       trig_mode,
  input  logic [DIV_W-1:0] div,
  input  logic             rd_next,
  output logic             armed,
  output logic             capturing,
  output logic             done,
  output logic             rd_data,
  output logic [PTR_W-1:0] rd_ptr
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  la_state_t        state, state_n;
  logic             arm_prev;
  logic             arm_req;
  logic [DIV_W-1:0] div_lat;
  logic             strobe;
  logic             prev, prev_valid;
  logic [PTR_W-1:0] wr_cnt;
  logic [DEPTH-1:0] sample_mem;

  logic start, smp_armed, trig_fire, cap_wr, rd_adv;

  // arm_prev follows arm even during reset, so an arm level held across
  // reset release is not mistaken for a fresh request.
  always_ff @(posedge clk) begin
    arm_prev <= arm;
  end

  assign arm_req = arm & ~arm_prev;

  yubex_la_strobe_gen #(.DIV_W(DIV_W)) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .en     ((state == ST_ARMED) || (state == ST_CAPTURE)),
    .clr    (start),
    .div    (div_lat),
    .strobe (strobe)
  );

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    smp_armed = 1'b0;
    trig_fire = 1'b0;
    cap_wr    = 1'b0;
    rd_adv    = 1'b0;
    if (!abort) begin
      case (state)
        ST_IDLE: begin
          if (arm_req) begin
            start   = 1'b1;
            state_n = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (strobe) begin
            smp_armed = 1'b1;
            // The first strobe only primes prev, so no edge is invented.
            if (prev_valid && trig_hit(trig_mode, prev, data_in)) begin
              trig_fire = 1'b1;
              state_n   = ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (strobe) begin
            cap_wr = 1'b1;
            if (wr_cnt == LAST_IDX) state_n = ST_DONE;
          end
        end
        default: begin
          if (arm_req) begin
            start   = 1'b1;
            state_n = ST_ARMED;
          end else if (rd_next) begin
            rd_adv = 1'b1;
          end
        end
      endcase
    end else begin
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_ptr     <= '0;
      wr_cnt     <= '0;
      prev       <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (abort) begin
        rd_ptr <= '0;
      end else if (start) begin
        rd_ptr     <= '0;
        wr_cnt     <= '0;
        prev_valid <= 1'b0;
      end else begin
        if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
        if (smp_armed) begin
          prev       <= data_in;
          prev_valid <= 1'b1;
        end
        if (trig_fire)   wr_cnt <= PTR_W'(1);
        else if (cap_wr) wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Sample buffer and latched divider carry no reset; they are only read
  // after being written in the current capture.
  always_ff @(posedge clk) begin
    if (start) div_lat <= div;
    if (trig_fire)   sample_mem[0]      <= data_in;
    else if (cap_wr) sample_mem[wr_cnt] <= data_in;
  end

  assign armed     = (state == ST_ARMED);
  assign capturing = (state == ST_CAPTURE);
  assign done      = (state == ST_DONE);
  assign rd_data   = done ? sample_mem[rd_ptr] : 1'b0;

endmodule
